// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared FSM states and counter sizing for the sequential divider
package seq_divider_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_bits(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step, subtracting by adding the complement with carry-in
module div_step #(parameter int WIDTH = 4) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);
  logic [WIDTH:0] r_sh, d_inv, t;
  logic carry, unused_top;
  assign r_sh = {r, q[WIDTH-1]};
  assign d_inv = ~{1'b0, d};
  assign {carry, t} = {1'b0, r_sh} + {1'b0, d_inv} + {{(WIDTH + 1){1'b0}}, 1'b1};
  assign {unused_top, r_next} = carry ? t : r_sh;
  assign q_next = {q[WIDTH-2:0], carry};
endmodule

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider producing one quotient bit per clock behind a start/done handshake
module seq_divider
  import seq_divider_pkg::*;
#(parameter int WIDTH = 4) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = cnt_bits(WIDTH);
  state_t state, state_next;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] r_acc, q_acc, d_reg, r_next, q_next;
  logic last_step, accept;
  div_step #(.WIDTH(WIDTH)) u_step (
    .r(r_acc), .q(q_acc), .d(d_reg), .r_next(r_next), .q_next(q_next)
  );
  assign last_step = cnt == CW'(1);
  assign accept = state == IDLE && start;
  // state register; reset abandons any operation in flight
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  // next state and handshake outputs
  always_comb begin
    state_next = IDLE;
    busy = state == RUN;
    done = state == DONE;
    if (state == IDLE) state_next = start ? (divisor != '0 ? RUN : DONE) : IDLE;
    else if (state == RUN) state_next = last_step ? DONE : RUN;
  end
  // operand capture, iteration and result registers; divide-by-zero resolves at capture
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      r_acc <= '0;
      q_acc <= '0;
      d_reg <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      div_by_zero <= divisor == '0;
      r_acc <= '0;
      q_acc <= dividend;
      d_reg <= divisor;
      cnt <= divisor == '0 ? '0 : CW'(WIDTH);
      if (divisor == '0) begin
        quotient <= '1;
        remainder <= dividend;
      end
    end else if (state == RUN) begin
      r_acc <= r_next;
      q_acc <= q_next;
      cnt <= cnt - CW'(1);
      if (last_step) begin
        quotient <= q_next;
        remainder <= r_next;
      end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider against an arithmetic reference
module tb_seq_divider;
  localparam int W = 4;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic busy, done, dbz;
  logic [W-1:0] quotient, remainder;
  logic [W-1:0] last_q = '0, last_r = '0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(dbz)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_q"}, 32'(quotient), 0);
    chk({tag, "_r"}, 32'(remainder), 0);
    chk({tag, "_dbz"}, 32'(dbz), 0);
  endtask

  // one full operation from IDLE: drive, accept, wait bounded for done, compare with plain arithmetic
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int cycles = 0, busy_cnt = 0;
    logic [W-1:0] eq, er;
    eq = b == 0 ? '1 : a / b;
    er = b == 0 ? a : a % b;
    start = 1'b1;
    dividend = a;
    divisor = b;
    step();
    start = 1'b0;
    dividend = W'($urandom);
    divisor = W'($urandom);
    if (b != 0) begin
      chk({tag, "_dbz_clr"}, 32'(dbz), 0);
      chk({tag, "_held_q"}, 32'(quotient), 32'(last_q));
      chk({tag, "_held_r"}, 32'(remainder), 32'(last_r));
    end
    while (!done && cycles < 3 * W) begin
      busy_cnt += int'(busy);
      step();
      cycles++;
    end
    chk({tag, "_latency"}, 32'(cycles), b == 0 ? 0 : W);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), b == 0 ? 0 : W);
    chk({tag, "_q"}, 32'(quotient), 32'(eq));
    chk({tag, "_r"}, 32'(remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(dbz), b == 0 ? 1 : 0);
    last_q = eq;
    last_r = er;
    step();
    chk({tag, "_done_pulse"}, 32'(done), 0);
  endtask

  initial begin
    int dones;
    logic [W-1:0] a, b;
    step();
    step();
    chk_zero("reset");
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk_zero("idle_reset");
    step();
    reset = 1'b0;
    op(4'd13, 4'd4, "d13_4");
    op(4'd15, 4'd1, "d15_1");
    step();
    step();
    chk("hold_q", 32'(quotient), 15);
    chk("hold_r", 32'(remainder), 0);
    op(4'd3, 4'd9, "d3_9");
    op(4'd7, 4'd0, "d7_0");
    op(4'd5, 4'd2, "after_dbz");
    // a second request during RUN must be dropped without queuing
    start = 1'b1;
    dividend = 4'd12;
    divisor = 4'd5;
    step();
    dividend = 4'd9;
    divisor = 4'd2;
    step();
    step();
    start = 1'b0;
    dones = 0;
    while (!done && dones < 3 * W) begin
      step();
      dones++;
    end
    chk("ign_done_seen", 32'(done), 1);
    chk("ign_q", 32'(quotient), 2);
    chk("ign_r", 32'(remainder), 2);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      dones += int'(done);
    end
    chk("ign_no_second_done", 32'(dones), 0);
    last_q = 4'd2;
    last_r = 4'd2;
    // reset in the second RUN cycle clears everything without waiting for a clock edge
    start = 1'b1;
    dividend = 4'd14;
    divisor = 4'd3;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk_zero("run_reset");
    step();
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      dones += int'(done);
    end
    chk("run_reset_no_done", 32'(dones), 0);
    last_q = '0;
    last_r = '0;
    op(4'd14, 4'd3, "d14_3");
    for (int i = 0; i < 128; i++) begin
      a = W'($urandom);
      b = $urandom_range(7) == 0 ? '0 : W'($urandom);
      op(a, b, "rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
